// File: rtl/data_pipe_interconnect_m2s_rr.sv
// -----------------------------------------------------------------------------
// data_pipe_interconnect_m2s_rr
// Many-to-one merge of NUM valid/ready upstream streams onto one downstream
// stream. A round-robin arbiter picks the next source. The output is
// registered and backed by a one-entry skid stage, so one beat per cycle is
// sustained. curr_path reports the source index of the beat on m00.
//
// Optional feature macro: DATA_PIPE_M2S_FIXED_PRI_EN
//   defined   : fixed priority, the lowest valid index always wins (no rr pointer)
//   undefined : round-robin starting after the last granted port
//
// Ports
//   clock      : clock
//   rst_n      : synchronous active-low reset
//   clk_en     : global enable, all state frozen and readies low when 0
//   curr_path  : source index of the beat presented on m00
//   s00_valid  : upstream valid, one bit per port
//   s00_ready  : upstream ready, one bit per port (combinational, at most one high)
//   s00_data   : upstream data, DSIZE bits per port
//   m00_valid  : downstream valid
//   m00_ready  : downstream ready
//   m00_data   : downstream data, forced to zero while m00_valid is low
// -----------------------------------------------------------------------------
module data_pipe_interconnect_m2s_rr #(
    parameter int unsigned NUM   = 8,
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NSIZE = $clog2(NUM)
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       clk_en,
    output logic [NSIZE-1:0]           curr_path,
    input  logic [NUM-1:0]             s00_valid,
    output logic [NUM-1:0]             s00_ready,
    input  logic [NUM-1:0][DSIZE-1:0]  s00_data,
    output logic                       m00_valid,
    input  logic                       m00_ready,
    output logic [DSIZE-1:0]           m00_data
);

    // Stage occupancy encoded as {out_vld, sk_vld}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic [NSIZE-1:0] id;
    } beat_t;

    state_e state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  sk_q, sk_d;

    logic             out_vld;
    logic             sk_vld;
    logic             gnt_vld;
    logic [NSIZE-1:0] gnt;
    logic             acc;
    logic             pop;
    beat_t            in_beat;

`ifndef DATA_PIPE_M2S_FIXED_PRI_EN
    localparam logic [NSIZE-1:0] LAST_RST = NSIZE'(NUM - 1);

    logic [NSIZE-1:0] last_q, last_d;
`endif

    assign out_vld = state_q[1];
    assign sk_vld  = state_q[0];

    // Arbiter: first valid port in scan order wins.
    always_comb begin
        logic [NSIZE-1:0] cand;
        int unsigned      idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM; k++) begin
`ifdef DATA_PIPE_M2S_FIXED_PRI_EN
            idx = k;
`else
            // Start one past the last granted port, wrapping at NUM.
            idx = (32'(last_q) + k + 1) % NUM;
`endif
            cand = NSIZE'(idx);
            if (!gnt_vld && s00_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    // Ready only toward the granted port, and only when the skid is free.
    always_comb begin
        s00_ready = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            s00_ready[i] = rst_n & clk_en & ~sk_vld & gnt_vld & (gnt == NSIZE'(i));
        end
    end

    assign acc          = gnt_vld & s00_valid[gnt] & s00_ready[gnt];
    assign pop          = out_vld & m00_ready & clk_en;
    assign in_beat.data = s00_data[gnt];
    assign in_beat.id   = gnt;

    // Next-state and stage loading.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sk_d    = sk_q;
        if (clk_en) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        out_d   = in_beat;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        out_d = in_beat;
                    end else if (acc) begin
                        sk_d    = in_beat;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Ready is low here, so only draining is possible.
                    if (pop) begin
                        out_d   = sk_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

`ifndef DATA_PIPE_M2S_FIXED_PRI_EN
    // Pointer follows every accepted grant; acc already implies clk_en.
    always_comb begin
        last_d = last_q;
        if (acc) begin
            last_d = gnt;
        end
    end
`endif

    // State registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            sk_q    <= '0;
`ifndef DATA_PIPE_M2S_FIXED_PRI_EN
            last_q  <= LAST_RST;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sk_q    <= sk_d;
`ifndef DATA_PIPE_M2S_FIXED_PRI_EN
            last_q  <= last_d;
`endif
        end
    end

    assign m00_valid = out_vld;
    assign m00_data  = out_vld ? out_q.data : '0;
    assign curr_path = out_q.id;

endmodule

// File: tb/tb_data_pipe_interconnect_m2s_rr.sv
// -----------------------------------------------------------------------------
// tb_data_pipe_interconnect_m2s_rr
// Directed bench for the many-to-one round-robin merge, NUM=4, DSIZE=8.
// Inputs change 1 time unit after the rising edge; outputs are observed there
// too, before the next edge.
// -----------------------------------------------------------------------------
module tb_data_pipe_interconnect_m2s_rr;

    logic            clock = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic [1:0]      curr_path;
    logic [3:0]      s00_valid;
    logic [3:0]      s00_ready;
    logic [3:0][7:0] s00_data;
    logic            m00_valid;
    logic            m00_ready;
    logic [7:0]      m00_data;

    // Observed output tuple {valid, data, path}.
    logic [10:0]     obs;
    assign obs = {m00_valid, m00_data, curr_path};

    int n_tests = 0;
    int n_fail  = 0;

    data_pipe_interconnect_m2s_rr #(
        .NUM   (4),
        .DSIZE (8)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .curr_path (curr_path),
        .s00_valid (s00_valid),
        .s00_ready (s00_ready),
        .s00_data  (s00_data),
        .m00_valid (m00_valid),
        .m00_ready (m00_ready),
        .m00_data  (m00_data)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s00_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        m00_ready = 1'b1;
        s00_valid = 4'b1111;
        s00_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        #1;
        n_tests++;
        if (s00_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready got %b want %b", s00_ready, 4'b0000);
        end
        step();
        n_tests++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_out got %h want %h", obs, 11'h000);
        end
        s00_valid = '0;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [10:0] exp;
        s00_valid   = 4'b0100;
        s00_data[2] = 8'h5A;
        m00_ready   = 1'b1;
        #1;
        n_tests++;
        if (s00_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got %b want %b", s00_ready, 4'b0100);
        end
        step();
        s00_valid = '0;
        exp = {1'b1, 8'h5A, 2'd2};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_out got %h want %h", obs, exp);
        end
        step();
        n_tests++;
        if (m00_valid !== 1'b0 || m00_data !== 8'h00) begin
            n_fail++;
            $display("FAIL single_drain got v=%b d=%h want v=0 d=00", m00_valid, m00_data);
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] exp;
        logic [1:0]  p;
        do_reset();
        s00_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        s00_valid = 4'b1111;
        m00_ready = 1'b1;
        #1;
        n_tests++;
        if (s00_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_first_ready got %b want %b", s00_ready, 4'b0001);
        end
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef DATA_PIPE_M2S_FIXED_PRI_EN
            p = 2'd0;
`else
            p = 2'(k % 4);
`endif
            exp = {1'b1, 8'h10 + 8'(p), p};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rr_beat%0d got %h want %h", k, obs, exp);
            end
        end
        s00_valid = '0;
        step();
        n_tests++;
        if (m00_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain got %b want 0", m00_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] exp;
        do_reset();
        m00_ready   = 1'b1;
        s00_valid   = 4'b0010;
        s00_data[1] = 8'hA0;
        step();
        s00_data[1] = 8'hA1;
        m00_ready   = 1'b0;
        #1;
        n_tests++;
        if (s00_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_ready_one got %b want %b", s00_ready, 4'b0010);
        end
        step();
        s00_data[1] = 8'hA2;
        for (int k = 0; k < 2; k++) begin
            exp = {1'b1, 8'hA0, 2'd1};
            n_tests++;
            if (obs !== exp || s00_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_full%0d got %h rdy %b want %h rdy 0000", k, obs, s00_ready, exp);
            end
            step();
        end
        // Output has been held through the full cycles; now release.
        m00_ready = 1'b1;
        step();
        exp = {1'b1, 8'hA1, 2'd1};
        n_tests++;
        if (obs !== exp || s00_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_skid_out got %h rdy %b want %h rdy 0010", obs, s00_ready, exp);
        end
        step();
        s00_valid = '0;
        exp = {1'b1, 8'hA2, 2'd1};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL bp_last got %h want %h", obs, exp);
        end
        step();
        n_tests++;
        if (m00_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got %b want 0", m00_valid);
        end
    endtask

    task automatic test_clk_en();
        logic [10:0] exp;
        m00_ready   = 1'b1;
        s00_valid   = 4'b1000;
        s00_data[3] = 8'hC0;
        step();
        s00_data[3] = 8'hC1;
        clk_en      = 1'b0;
        exp = {1'b1, 8'hC0, 2'd3};
        #1;
        n_tests++;
        if (s00_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL ce_ready got %b want 0000", s00_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (obs !== exp || s00_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL ce_hold%0d got %h rdy %b want %h rdy 0000", k, obs, s00_ready, exp);
            end
        end
        clk_en = 1'b1;
        #1;
        n_tests++;
        if (s00_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL ce_resume_ready got %b want %b", s00_ready, 4'b1000);
        end
        step();
        s00_valid = '0;
        exp = {1'b1, 8'hC1, 2'd3};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL ce_resume got %h want %h", obs, exp);
        end
        step();
    endtask

    task automatic test_reset_full();
        logic [10:0] exp;
        do_reset();
        m00_ready   = 1'b0;
        s00_valid   = 4'b0100;
        s00_data[2] = 8'hD0;
        step();
        s00_data[2] = 8'hD1;
        step();
        exp = {1'b1, 8'hD0, 2'd2};
        n_tests++;
        if (obs !== exp || s00_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rf_full got %h rdy %b want %h rdy 0000", obs, s00_ready, exp);
        end
        rst_n     = 1'b0;
        s00_valid = 4'b1111;
        s00_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        step();
        n_tests++;
        if (obs !== 11'h000) begin
            n_fail++;
            $display("FAIL rf_cleared got %h want %h", obs, 11'h000);
        end
        rst_n     = 1'b1;
        m00_ready = 1'b1;
        #1;
        n_tests++;
        if (s00_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rf_first_grant got %b want %b", s00_ready, 4'b0001);
        end
        step();
        s00_valid = '0;
        exp = {1'b1, 8'h10, 2'd0};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rf_first_beat got %h want %h", obs, exp);
        end
        step();
    endtask

    task automatic test_two_ports();
        logic [1:0] p;
        logic [3:0] rdy_exp;
        do_reset();
        m00_ready = 1'b1;
        s00_data  = {8'h73, 8'h72, 8'h71, 8'h70};
        s00_valid = 4'b1001;
        for (int k = 0; k < 6; k++) begin
`ifdef DATA_PIPE_M2S_FIXED_PRI_EN
            p = 2'd0;
`else
            p = (k % 2 == 0) ? 2'd0 : 2'd3;
`endif
            rdy_exp = 4'b0001 << p;
            #1;
            n_tests++;
            if (s00_ready !== rdy_exp) begin
                n_fail++;
                $display("FAIL two_ready%0d got %b want %b", k, s00_ready, rdy_exp);
            end
            step();
            n_tests++;
            if (curr_path !== p || m00_data !== 8'h70 + 8'(p)) begin
                n_fail++;
                $display("FAIL two_beat%0d got p=%0d d=%h want p=%0d d=%h", k, curr_path, m00_data, p, 8'h70 + 8'(p));
            end
        end
        s00_valid = '0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        m00_ready = 1'b0;
        s00_valid = '0;
        s00_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_clk_en();
        test_reset_full();
        test_two_ports();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
